// File: rtl/dmem_arbiter_if.sv
// One requester port of the data-memory arbiter: request/grant handshake plus read return.
// master = requester side, slave = arbiter side.
interface dmem_arbiter_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 32
);
   logic              req;
   logic              we;
   logic              lock;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              gnt;
   logic              rvalid;
   logic [DATA_W-1:0] rdata;
   logic              err;

   modport master (
      output req, we, lock, addr, wdata,
      input  gnt, rvalid, rdata, err
   );

   modport slave (
      input  req, we, lock, addr, wdata,
      output gnt, rvalid, rdata, err
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of data_memory with out-of-range rejection,
// 1-cycle read-return routing and a bounded lock for read-modify-write sequences.
module dmem_arbiter #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned DEPTH    = 32,
   parameter int unsigned LOCK_MAX = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   dmem_arbiter_if.slave     p0_if,
   dmem_arbiter_if.slave     p1_if,
   output logic              m_write_o,
   output logic              m_read_o,
   output logic [ADDR_W-1:0] m_addr_o,
   output logic [DATA_W-1:0] m_wdata_o,
   input  logic [DATA_W-1:0] m_rdata_i
);
   localparam int unsigned CntW = $clog2(LOCK_MAX);

   typedef enum logic [1:0] {StIdle, StLock0, StLock1} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            last_q, last_d;
   logic            rv_q, rv_d;
   logic            rsel_q, rsel_d;
   logic [1:0]      err_q, err_d;

   logic [1:0]        req;
   logic [1:0]        elig;
   logic              forced;
   logic              win_valid;
   logic              win_id;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              sel_we;
   logic              sel_lock;
   logic              legal;
   logic              own_id;

   assign req = {p1_if.req, p0_if.req};

   // Lock owner has exclusive access until its forced-release cycle, where the other port wins.
   always_comb begin
      forced = (cnt_q == CntW'(LOCK_MAX - 1));
      elig   = '0;
      case (state_q)
         StLock0: elig = forced ? {req[1], req[0] & ~req[1]} : {1'b0, req[0]};
         StLock1: elig = forced ? {req[1] & ~req[0], req[0]} : {req[1], 1'b0};
         default: elig = req;
      endcase
      if (!rst_n) elig = '0;
   end

   assign win_valid = |elig;
   assign win_id    = (&elig) ? ~last_q : elig[1];
   assign own_id    = (state_q == StLock1);

   assign sel_addr  = win_id ? p1_if.addr  : p0_if.addr;
   assign sel_wdata = win_id ? p1_if.wdata : p0_if.wdata;
   assign sel_we    = win_id ? p1_if.we    : p0_if.we;
   assign sel_lock  = win_id ? p1_if.lock  : p0_if.lock;
   assign legal     = (64'(sel_addr) < 64'(DEPTH));

   assign p0_if.gnt = win_valid & ~win_id;
   assign p1_if.gnt = win_valid & win_id;
   assign m_addr_o  = win_valid ? sel_addr : '0;
   assign m_wdata_o = win_valid ? sel_wdata : '0;
   assign m_write_o = win_valid & legal & sel_we;
   assign m_read_o  = win_valid & legal & ~sel_we;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      last_d  = win_valid ? win_id : last_q;
      rv_d    = win_valid & legal & ~sel_we;
      rsel_d  = win_id;
      err_d   = (win_valid && !legal) ? (win_id ? 2'b10 : 2'b01) : 2'b00;
      case (state_q)
         StIdle: begin
            if (win_valid && sel_lock) begin
               state_d = win_id ? StLock1 : StLock0;
               cnt_d   = '0;
            end
         end
         StLock0, StLock1: begin
            cnt_d = cnt_q + CntW'(1);
            if (forced || (win_valid && (win_id == own_id) && !sel_lock)) begin
               state_d = StIdle;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         last_q  <= 1'b1;
         rv_q    <= 1'b0;
         rsel_q  <= 1'b0;
         err_q   <= 2'b00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         rv_q    <= rv_d;
         rsel_q  <= rsel_d;
         err_q   <= err_d;
      end
   end

   assign p0_if.rvalid = rv_q & ~rsel_q;
   assign p1_if.rvalid = rv_q & rsel_q;
   assign p0_if.rdata  = p0_if.rvalid ? m_rdata_i : '0;
   assign p1_if.rdata  = p1_if.rvalid ? m_rdata_i : '0;
   assign p0_if.err    = err_q[0];
   assign p1_if.err    = err_q[1];
endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed bench for dmem_arbiter against a transaction-level reference model.
module tb_dmem_arbiter;
   localparam int unsigned DW       = 32;
   localparam int unsigned AW       = 32;
   localparam int unsigned DEPTH    = 32;
   localparam int unsigned LOCK_MAX = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dmem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) p0_if ();
   dmem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) p1_if ();

   logic          m_write, m_read;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata, m_rdata;

   dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .LOCK_MAX(LOCK_MAX)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .p0_if     (p0_if),
      .p1_if     (p1_if),
      .m_write_o (m_write),
      .m_read_o  (m_read),
      .m_addr_o  (m_addr),
      .m_wdata_o (m_wdata),
      .m_rdata_i (m_rdata)
   );

   // data_memory stand-in: registered read
   logic [DW-1:0] mem [DEPTH];
   always @(posedge clk) begin
      if (m_write && m_addr < DEPTH) mem[m_addr[4:0]] <= m_wdata;
      if (m_read && m_addr < DEPTH) m_rdata <= mem[m_addr[4:0]];
   end

   // stimulus
   bit            rq [2];
   bit            wv [2];
   bit            lk [2];
   logic [AW-1:0] ad [2];
   logic [DW-1:0] wd [2];

   // reference model: owner of the lock (-1 none), cycles held, last winner, expected returns
   int            owner = -1;
   int            held  = 0;
   int            last  = 1;
   bit            exp_rv [2];
   bit            exp_err [2];
   logic [DW-1:0] exp_rdata;
   logic [DW-1:0] ref_mem [DEPTH];
   bit            mgnt [2];

   bit            obs_gnt [2];
   logic [DW-1:0] obs_rdata0;
   bit            obs_err1, obs_rv1;

   int n_chk = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
   endtask

   task automatic drive();
      p0_if.req = rq[0]; p0_if.we = wv[0]; p0_if.lock = lk[0]; p0_if.addr = ad[0]; p0_if.wdata = wd[0];
      p1_if.req = rq[1]; p1_if.we = wv[1]; p1_if.lock = lk[1]; p1_if.addr = ad[1]; p1_if.wdata = wd[1];
   endtask

   task automatic set_port(input int j, input bit r, input bit w, input bit l,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
      rq[j] = r; wv[j] = w; lk[j] = l; ad[j] = a; wd[j] = d;
   endtask

   task automatic step();
      int            win;
      bit            e0, e1, frc, legal, ew, er;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      @(posedge clk); #1;
      drive();
      #4;
      frc = (owner >= 0) && (held == LOCK_MAX - 1);
      if (owner < 0) begin
         e0 = rq[0]; e1 = rq[1];
      end else if (!frc) begin
         e0 = (owner == 0) && rq[0]; e1 = (owner == 1) && rq[1];
      end else begin
         e0 = (owner == 0) ? (rq[0] && !rq[1]) : rq[0];
         e1 = (owner == 1) ? (rq[1] && !rq[0]) : rq[1];
      end
      win = -1;
      if (e0 && e1) win = 1 - last;
      else if (e0) win = 0;
      else if (e1) win = 1;
      legal = 1'b0; ew = 1'b0; er = 1'b0; ea = '0; ed = '0;
      if (win >= 0) begin
         legal = ad[win] < DEPTH;
         ew = legal && wv[win];
         er = legal && !wv[win];
         ea = ad[win];
         ed = wd[win];
      end
      check("p0_gnt", p0_if.gnt, win == 0);
      check("p1_gnt", p1_if.gnt, win == 1);
      check("m_write", m_write, ew);
      check("m_read", m_read, er);
      check("m_addr", m_addr, ea);
      check("m_wdata", m_wdata, ed);
      check("p0_rvalid", p0_if.rvalid, exp_rv[0]);
      check("p1_rvalid", p1_if.rvalid, exp_rv[1]);
      check("p0_rdata", p0_if.rdata, exp_rv[0] ? exp_rdata : '0);
      check("p1_rdata", p1_if.rdata, exp_rv[1] ? exp_rdata : '0);
      check("p0_err", p0_if.err, exp_err[0]);
      check("p1_err", p1_if.err, exp_err[1]);
      obs_gnt[0] = p0_if.gnt; obs_gnt[1] = p1_if.gnt;
      obs_rdata0 = p0_if.rdata; obs_err1 = p1_if.err; obs_rv1 = p1_if.rvalid;
      mgnt[0] = (win == 0); mgnt[1] = (win == 1);
      exp_rv = '{0, 0}; exp_err = '{0, 0};
      if (win >= 0) begin
         last = win;
         if (!legal) exp_err[win] = 1'b1;
         else if (wv[win]) ref_mem[ad[win]] = wd[win];
         else begin
            exp_rv[win] = 1'b1;
            exp_rdata = ref_mem[ad[win]];
         end
      end
      if (owner < 0) begin
         if (win >= 0 && lk[win]) begin
            owner = win;
            held = 0;
         end
      end else if (frc || (win == owner && !lk[owner])) owner = -1;
      else held++;
   endtask

   task automatic reset_dut();
      @(posedge clk); #1;
      rst_n = 1'b0;
      set_port(0, 1, 0, 1, 5, 0);
      set_port(1, 1, 1, 0, 6, 32'h1234);
      drive();
      #4;
      check("rst_p0_gnt", p0_if.gnt, 0);
      check("rst_p1_gnt", p1_if.gnt, 0);
      check("rst_m_rw", {m_write, m_read}, 0);
      check("rst_m_addr", m_addr, 0);
      check("rst_m_wdata", m_wdata, 0);
      check("rst_rvalid", {p0_if.rvalid, p1_if.rvalid}, 0);
      check("rst_rdata", {p0_if.rdata, p1_if.rdata}, 0);
      check("rst_err", {p0_if.err, p1_if.err}, 0);
      owner = -1; held = 0; last = 1;
      exp_rv = '{0, 0}; exp_err = '{0, 0}; mgnt = '{0, 0};
      repeat (2) @(posedge clk);
      #1;
      set_port(0, 0, 0, 0, 0, 0);
      set_port(1, 0, 0, 0, 0, 0);
      drive();
      rst_n = 1'b1;
   endtask

   initial begin
      int waited;
      bit found;
      set_port(0, 0, 0, 0, 0, 0);
      set_port(1, 0, 0, 0, 0, 0);
      drive();
      reset_dut();

      // fill memory so every legal read has a known value
      for (int i = 0; i < DEPTH; i++) begin
         set_port(0, 1, 1, 0, i, $urandom);
         step();
      end

      set_port(0, 1, 1, 0, 5, 32'hDEADBEEF); step();
      set_port(0, 1, 0, 0, 5, 0);            step();
      set_port(0, 0, 0, 0, 0, 0);            step();
      check("rd5_data", obs_rdata0, 32'hDEADBEEF);

      // both ports hold reads: grants must alternate
      set_port(0, 1, 0, 0, 1, 0);
      set_port(1, 1, 0, 0, 2, 0);
      step(); found = obs_gnt[0];
      for (int i = 0; i < 3; i++) begin
         step();
         check("alternate", obs_gnt[0], !found);
         found = obs_gnt[0];
      end
      set_port(0, 0, 0, 0, 0, 0);
      set_port(1, 1, 0, 0, 32, 0); step();
      check("oob_gnt", obs_gnt[1], 1);
      set_port(1, 0, 0, 0, 0, 0); step();
      check("oob_err", obs_err1, 1);
      check("oob_norv", obs_rv1, 0);

      // lock read then unlocked write; p1 waits
      set_port(0, 1, 0, 1, 3, 0); step();
      set_port(0, 1, 1, 0, 3, 32'hA5A5A5A5);
      set_port(1, 1, 0, 0, 3, 0); step();
      check("lock_p1_wait", obs_gnt[1], 0);
      set_port(0, 0, 0, 0, 0, 0); step();
      check("lock_p1_after", obs_gnt[1], 1);
      set_port(1, 0, 0, 0, 0, 0); step();

      // continuous lock must be force-released to a waiting p1
      set_port(0, 1, 0, 1, 7, 0); step();
      set_port(1, 1, 0, 0, 8, 0);
      found = 0; waited = 0;
      for (int i = 0; i < LOCK_MAX + 1; i++) begin
         if (!found) begin
            step();
            waited++;
            if (obs_gnt[1]) found = 1;
         end
      end
      check("lock_bound", found, 1);
      set_port(1, 0, 0, 0, 0, 0); step();
      set_port(0, 1, 0, 0, 7, 0); step();
      set_port(0, 0, 0, 0, 0, 0); step();

      // reset right after a read grant: no stale return, first tie goes to p0
      set_port(0, 1, 0, 0, 5, 0); step();
      reset_dut();
      set_port(0, 1, 0, 0, 9, 0);
      set_port(1, 1, 0, 0, 10, 0); step();
      check("post_rst_tie", obs_gnt[0], 1);
      set_port(0, 0, 0, 0, 0, 0);
      set_port(1, 0, 0, 0, 0, 0); step();

      for (int n = 0; n < 600; n++) begin
         for (int j = 0; j < 2; j++) begin
            if (!(rq[j] && !mgnt[j]))
               set_port(j, ($urandom % 4) != 0, $urandom % 2, ($urandom % 4) == 0,
                        $urandom_range(0, DEPTH + 7), $urandom);
         end
         step();
      end
      set_port(0, 0, 0, 0, 0, 0);
      set_port(1, 0, 0, 0, 0, 0);
      step();
      step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
